// File: rtl/muldiv_sched.sv
// HI/LO scheduler for an external multiply/divide unit: operand handshake, launch/busy/commit
// sequencing, flush and watchdog abort. Define MULDIV_SCHED_ACC_EN to enable MADD/MSUB.
module muldiv_sched #(
    parameter int unsigned N       = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         op_valid,
    output logic         op_ready,
    input  logic [2:0]   op_code,
    input  logic         op_sign,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         rd_hi,
    input  logic         rd_lo,
    output logic [N-1:0] rd_data,
    output logic         rd_stall,
    output logic         u_mul,
    output logic         u_div,
    output logic         u_sign,
    output logic         u_add,
    output logic         u_sub,
    output logic         u_clear,
    output logic         u_hold,
    output logic [N-1:0] u_a,
    output logic [N-1:0] u_b,
    output logic [N-1:0] u_hi_in,
    output logic [N-1:0] u_lo_in,
    input  logic [N-1:0] u_hi_out,
    input  logic [N-1:0] u_lo_out,
    input  logic         u_write,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         timeout_err
);

    localparam logic [2:0] OpMult = 3'b000;
    localparam logic [2:0] OpDiv  = 3'b001;
    localparam logic [2:0] OpMthi = 3'b010;
    localparam logic [2:0] OpMtlo = 3'b011;
    localparam logic [2:0] OpMadd = 3'b100;
    localparam logic [2:0] OpMsub = 3'b101;

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StCommit} state_e;

    state_e          state_q;
    logic [N-1:0]    hi_q, lo_q, a_q, b_q;
    logic            sign_q;
    logic [2:0]      op_q;
    logic [CntW-1:0] cnt_q;
    logic            timeout_q;
    logic            clear_q;

    logic launch_op;
    logic in_flight;
    logic mul_class;

    always_comb begin
        launch_op = (op_code == OpMult) || (op_code == OpDiv);
`ifdef MULDIV_SCHED_ACC_EN
        launch_op = launch_op || (op_code == OpMadd) || (op_code == OpMsub);
        mul_class = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpMsub);
`else
        mul_class = (op_q == OpMult);
`endif
        in_flight = (state_q == StLaunch) || (state_q == StBusy);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            lo_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            op_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            clear_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            clear_q   <= 1'b0;
            // Flush beats both a same-cycle commit and a same-cycle watchdog abort.
            if (flush && (state_q != StIdle)) begin
                state_q <= StIdle;
                clear_q <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (op_valid && !flush) begin
                            if (op_code == OpMthi) begin
                                hi_q <= op_a;
                            end else if (op_code == OpMtlo) begin
                                lo_q <= op_a;
                            end else if (launch_op) begin
                                a_q     <= op_a;
                                b_q     <= op_b;
                                sign_q  <= op_sign;
                                op_q    <= op_code;
                                cnt_q   <= '0;
                                state_q <= StLaunch;
                            end
                        end
                    end
                    StLaunch: begin
                        state_q <= StBusy;
                    end
                    StBusy: begin
                        if (u_write) begin
                            hi_q    <= u_hi_out;
                            lo_q    <= u_lo_out;
                            state_q <= StCommit;
                        end else if (cnt_q == CntLast) begin
                            state_q   <= StIdle;
                            timeout_q <= 1'b1;
                            clear_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StCommit: begin
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    always_comb begin
        op_ready = !reset && !flush && (state_q == StIdle);
        u_mul    = !reset && in_flight && mul_class;
        u_div    = !reset && in_flight && (op_q == OpDiv);
        u_sign   = !reset && sign_q;
        u_hold   = !reset && (state_q == StBusy);
        u_clear  = reset || clear_q;
`ifdef MULDIV_SCHED_ACC_EN
        u_add    = !reset && in_flight && (op_q == OpMadd);
        u_sub    = !reset && in_flight && (op_q == OpMsub);
`else
        u_add    = 1'b0;
        u_sub    = 1'b0;
`endif
    end

    assign u_a         = a_q;
    assign u_b         = b_q;
    assign u_hi_in     = hi_q;
    assign u_lo_in     = lo_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign timeout_err = timeout_q;

    assign rd_data  = rd_hi ? hi_q : (rd_lo ? lo_q : '0);
    assign rd_stall = (rd_hi || rd_lo) && (state_q != StIdle);

endmodule

// File: tb/tb_muldiv_sched.sv
// Scoreboarded bench for muldiv_sched: a behavioural arithmetic unit supplies results, and
// expected HI/LO pairs are queued at issue and compared after each operation settles.
module tb_muldiv_sched;

    localparam int N = 32;
    localparam logic [2:0] OpMult = 3'b000;
    localparam logic [2:0] OpDiv  = 3'b001;
    localparam logic [2:0] OpMthi = 3'b010;
    localparam logic [2:0] OpMtlo = 3'b011;
    localparam logic [2:0] OpMadd = 3'b100;
    localparam logic [2:0] OpMsub = 3'b101;

    logic         clk = 1'b0;
    logic         reset, flush, op_valid, op_ready, op_sign;
    logic [2:0]   op_code;
    logic [N-1:0] op_a, op_b, rd_data;
    logic         rd_hi, rd_lo, rd_stall;
    logic         u_mul, u_div, u_sign, u_add, u_sub, u_clear, u_hold, u_write;
    logic [N-1:0] u_a, u_b, u_hi_in, u_lo_in, u_hi_out, u_lo_out, hi, lo;
    logic         timeout_err;

    int checks = 0;
    int errors = 0;
    logic [63:0]  exp_q[$];
    logic [63:0]  exp_v;
    logic [N-1:0] model_hi, model_lo;

    muldiv_sched #(.N(N), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .flush(flush), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_sign(op_sign), .op_a(op_a), .op_b(op_b),
        .rd_hi(rd_hi), .rd_lo(rd_lo), .rd_data(rd_data), .rd_stall(rd_stall),
        .u_mul(u_mul), .u_div(u_div), .u_sign(u_sign), .u_add(u_add), .u_sub(u_sub),
        .u_clear(u_clear), .u_hold(u_hold), .u_a(u_a), .u_b(u_b),
        .u_hi_in(u_hi_in), .u_lo_in(u_lo_in), .u_hi_out(u_hi_out), .u_lo_out(u_lo_out),
        .u_write(u_write), .hi(hi), .lo(lo), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [2:0] code, input logic sign,
                          input logic [N-1:0] a, input logic [N-1:0] b);
        op_valid = 1'b1; op_code = code; op_sign = sign; op_a = a; op_b = b;
        tick();
        op_valid = 1'b0; op_a = '0; op_b = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        checks++; if (op_ready !== 1'b0) begin errors++;
            $display("FAIL reset_op_ready: got %0b want 0", op_ready); end
        checks++; if (u_clear !== 1'b1) begin errors++;
            $display("FAIL reset_u_clear: got %0b want 1", u_clear); end
        checks++; if ({u_mul, u_div, u_sign, u_add, u_sub, u_hold} !== 6'b0) begin errors++;
            $display("FAIL reset_u_ctrl: got %b want 000000",
                     {u_mul, u_div, u_sign, u_add, u_sub, u_hold}); end
        checks++; if ({hi, lo, timeout_err} !== 65'b0) begin errors++;
            $display("FAIL reset_regs: got hi=%h lo=%h to=%b want 0", hi, lo, timeout_err); end
        reset = 1'b0;
        tick();
        checks++; if ({op_ready, u_clear} !== 2'b10) begin errors++;
            $display("FAIL reset_release: got ready=%b clear=%b want 1 0", op_ready, u_clear); end
        model_hi = '0; model_lo = '0;
    endtask

    task automatic test_mthi_mtlo();
        rd_hi = 1'b1;
        op_valid = 1'b1; op_code = OpMthi; op_sign = 1'b0; op_a = 32'h1234; op_b = '0;
        #1;
        checks++; if (rd_data !== model_hi) begin errors++;
            $display("FAIL mthi_same_cycle_read: got %h want %h", rd_data, model_hi); end
        exp_q.push_back({32'h1234, model_lo});
        tick();
        op_valid = 1'b0;
        model_hi = 32'h1234;
        checks++; if ({rd_data, rd_stall} !== {32'h1234, 1'b0}) begin errors++;
            $display("FAIL mthi_read: got %h stall=%b want 1234 0", rd_data, rd_stall); end
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL mthi_regs: got %h want %h", {hi, lo}, exp_v); end
        rd_hi = 1'b0;
        exp_q.push_back({model_hi, 32'h5678});
        accept(OpMtlo, 1'b0, 32'h5678, '0);
        model_lo = 32'h5678;
        rd_lo = 1'b1; #1;
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo, rd_data} !== {exp_v, 32'h5678}) begin errors++;
            $display("FAIL mtlo_read: got %h/%h want %h", {hi, lo}, rd_data, exp_v); end
        rd_lo = 1'b0;
    endtask

    task automatic test_mult();
        logic [63:0] prod;
        longint p;
        int bad;
        p = -3 * 5;
        prod = p;
        exp_q.push_back(prod);
        rd_lo = 1'b1;
        accept(OpMult, 1'b1, 32'hFFFF_FFFD, 32'd5);
        checks++; if ({u_mul, u_div, u_hold, u_sign, rd_stall, op_ready} !== 6'b100110)
        begin errors++;
            $display("FAIL mult_launch: got mul%b div%b hold%b sign%b stall%b rdy%b",
                     u_mul, u_div, u_hold, u_sign, rd_stall, op_ready); end
        checks++; if ({u_a, u_b} !== {32'hFFFF_FFFD, 32'd5}) begin errors++;
            $display("FAIL mult_operands: got %h %h want fffffffd 5", u_a, u_b); end
        tick();
        bad = 0;
        for (int i = 1; i < 34; i++) begin
            if (!(rd_stall && u_hold && u_mul && u_sign && u_a == 32'hFFFF_FFFD)) bad++;
            tick();
        end
        u_write = 1'b1; u_hi_out = prod[63:32]; u_lo_out = prod[31:0];
        tick();
        u_write = 1'b0; u_hi_out = '0; u_lo_out = '0;
        checks++; if (bad != 0) begin errors++;
            $display("FAIL mult_busy_cycles: got %0d bad cycles want 0", bad); end
        checks++; if ({u_mul, u_hold, rd_stall, op_ready} !== 4'b0010) begin errors++;
            $display("FAIL mult_commit_ctrl: got mul%b hold%b stall%b rdy%b want 0 0 1 0",
                     u_mul, u_hold, rd_stall, op_ready); end
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL mult_result: got %h want %h", {hi, lo}, exp_v); end
        tick();
        checks++; if ({op_ready, rd_stall, rd_data} !== {2'b10, 32'hFFFF_FFF1}) begin errors++;
            $display("FAIL mult_idle_read: got rdy%b stall%b %h", op_ready, rd_stall, rd_data); end
        rd_lo = 1'b0;
        model_hi = prod[63:32]; model_lo = prod[31:0];
    endtask

    task automatic test_madd();
        logic [63:0] acc;
        accept(OpMthi, 1'b0, 32'd0, '0);
        accept(OpMtlo, 1'b0, 32'd10, '0);
        model_hi = '0; model_lo = 32'd10;
`ifdef MULDIV_SCHED_ACC_EN
        acc = {model_hi, model_lo} + 64'd6;
        exp_q.push_back(acc);
        accept(OpMadd, 1'b0, 32'd2, 32'd3);
        checks++; if ({u_mul, u_add, u_sub, u_lo_in} !== {3'b110, 32'd10}) begin errors++;
            $display("FAIL madd_launch: got mul%b add%b sub%b lo_in=%h",
                     u_mul, u_add, u_sub, u_lo_in); end
        tick();
        checks++; if ({u_add, u_hold} !== 2'b11) begin errors++;
            $display("FAIL madd_busy: got add%b hold%b want 1 1", u_add, u_hold); end
        u_write = 1'b1; u_hi_out = acc[63:32]; u_lo_out = acc[31:0];
        tick();
        u_write = 1'b0;
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo, u_add} !== {exp_v, 1'b0}) begin errors++;
            $display("FAIL madd_result: got %h add%b want %h", {hi, lo}, u_add, exp_v); end
        tick();
        acc = acc - 64'd4;
        exp_q.push_back(acc);
        accept(OpMsub, 1'b0, 32'd1, 32'd4);
        checks++; if ({u_sub, u_add, u_mul} !== 3'b101) begin errors++;
            $display("FAIL msub_launch: got sub%b add%b mul%b", u_sub, u_add, u_mul); end
        tick();
        u_write = 1'b1; u_hi_out = acc[63:32]; u_lo_out = acc[31:0];
        tick();
        u_write = 1'b0;
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL msub_result: got %h want %h", {hi, lo}, exp_v); end
        tick();
        model_hi = acc[63:32]; model_lo = acc[31:0];
`else
        acc = {model_hi, model_lo};
        exp_q.push_back(acc);
        accept(OpMadd, 1'b0, 32'd2, 32'd3);
        checks++; if ({op_ready, u_mul, u_add, u_hold} !== 4'b1000) begin errors++;
            $display("FAIL madd_noop: got rdy%b mul%b add%b hold%b want 1 0 0 0",
                     op_ready, u_mul, u_add, u_hold); end
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL madd_noop_regs: got %h want %h", {hi, lo}, exp_v); end
        accept(OpMsub, 1'b0, 32'd1, 32'd4);
        checks++; if ({op_ready, u_mul, u_sub} !== 3'b100) begin errors++;
            $display("FAIL msub_noop: got rdy%b mul%b sub%b", op_ready, u_mul, u_sub); end
`endif
    endtask

    task automatic test_flush();
        exp_q.push_back({model_hi, model_lo});
        accept(OpDiv, 1'b0, 32'd100, 32'd7);
        tick();
        repeat (4) tick();
        checks++; if ({u_div, u_mul, u_hold, u_clear} !== 4'b1010) begin errors++;
            $display("FAIL flush_busy5: got div%b mul%b hold%b clr%b",
                     u_div, u_mul, u_hold, u_clear); end
        flush = 1'b1; #1;
        checks++; if (op_ready !== 1'b0) begin errors++;
            $display("FAIL flush_ready: got %b want 0", op_ready); end
        tick();
        flush = 1'b0; #1;
        exp_v = exp_q.pop_front();
        checks++; if ({u_clear, op_ready, u_div, u_hold} !== 4'b1100) begin errors++;
            $display("FAIL flush_abort: got clr%b rdy%b div%b hold%b",
                     u_clear, op_ready, u_div, u_hold); end
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL flush_regs: got %h want %h", {hi, lo}, exp_v); end
        tick();
        checks++; if (u_clear !== 1'b0) begin errors++;
            $display("FAIL flush_clear_pulse: got %b want 0", u_clear); end
    endtask

    task automatic test_timeout();
        int bad;
        exp_q.push_back({model_hi, model_lo});
        accept(OpMult, 1'b0, 32'd6, 32'd7);
        tick();
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (!u_hold || timeout_err || u_clear) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errors++;
            $display("FAIL timeout_busy: got %0d bad cycles want 0", bad); end
        checks++; if ({timeout_err, u_clear, op_ready, u_hold} !== 4'b1110) begin errors++;
            $display("FAIL timeout_abort: got to%b clr%b rdy%b hold%b",
                     timeout_err, u_clear, op_ready, u_hold); end
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL timeout_regs: got %h want %h", {hi, lo}, exp_v); end
        tick();
        checks++; if ({timeout_err, u_clear, op_ready} !== 3'b001) begin errors++;
            $display("FAIL timeout_after: got to%b clr%b rdy%b", timeout_err, u_clear, op_ready); end
    endtask

    task automatic test_flush_write();
        exp_q.push_back({model_hi, model_lo});
        accept(OpMult, 1'b0, 32'd6, 32'd7);
        tick();
        u_write = 1'b1; u_hi_out = 32'hDEAD; u_lo_out = 32'hBEEF; flush = 1'b1;
        op_valid = 1'b1; op_code = OpMthi; op_a = 32'h9999;
        tick();
        u_write = 1'b0; flush = 1'b0; op_valid = 1'b0; #1;
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo, u_clear, op_ready} !== {exp_v, 2'b11}) begin errors++;
            $display("FAIL flush_vs_write: got %h clr%b rdy%b want %h 1 1",
                     {hi, lo}, u_clear, op_ready, exp_v); end
        tick();
        exp_q.push_back({model_hi, model_lo});
        flush = 1'b1; op_valid = 1'b1; op_code = OpMtlo; op_a = 32'h7777; #1;
        checks++; if (op_ready !== 1'b0) begin errors++;
            $display("FAIL flush_idle_ready: got %b want 0", op_ready); end
        tick();
        flush = 1'b0; op_valid = 1'b0; #1;
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo, u_clear} !== {exp_v, 1'b0}) begin errors++;
            $display("FAIL flush_vs_valid: got %h clr%b want %h 0", {hi, lo}, u_clear, exp_v); end
    endtask

    task automatic test_back_to_back();
        int qi, ri;
        logic [N-1:0] q, r;
        logic [63:0] prod;
        qi = -20 / 3; ri = -20 % 3;
        q = qi; r = ri;
        exp_q.push_back({r, q});
        accept(OpDiv, 1'b1, 32'hFFFF_FFEC, 32'd3);
        checks++; if ({u_div, u_mul, u_sign} !== 3'b101) begin errors++;
            $display("FAIL div_launch: got div%b mul%b sign%b", u_div, u_mul, u_sign); end
        tick(); tick(); tick();
        u_write = 1'b1; u_hi_out = r; u_lo_out = q;
        tick();
        u_write = 1'b0;
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL div_result: got %h want %h", {hi, lo}, exp_v); end
        tick();
        checks++; if (op_ready !== 1'b1) begin errors++;
            $display("FAIL b2b_ready: got %b want 1", op_ready); end
        prod = 64'(32'hFFFF_FFFF) * 64'd2;
        exp_q.push_back(prod);
        accept(OpMult, 1'b0, 32'hFFFF_FFFF, 32'd2);
        checks++; if ({u_mul, u_sign} !== 2'b10) begin errors++;
            $display("FAIL b2b_launch: got mul%b sign%b want 1 0", u_mul, u_sign); end
        tick();
        u_write = 1'b1; u_hi_out = prod[63:32]; u_lo_out = prod[31:0];
        tick();
        u_write = 1'b0;
        exp_v = exp_q.pop_front();
        checks++; if ({hi, lo} !== exp_v) begin errors++;
            $display("FAIL b2b_result: got %h want %h", {hi, lo}, exp_v); end
        tick();
        model_hi = prod[63:32]; model_lo = prod[31:0];
    endtask

    task automatic test_reset_mid();
        accept(OpMult, 1'b0, 32'd3, 32'd3);
        tick();
        reset = 1'b1; u_write = 1'b1; u_hi_out = 32'h1111; u_lo_out = 32'h2222;
        tick();
        u_write = 1'b0;
        checks++; if ({hi, lo, u_clear, op_ready, u_hold} !== {64'b0, 3'b100}) begin errors++;
            $display("FAIL reset_mid: got %h clr%b rdy%b hold%b",
                     {hi, lo}, u_clear, op_ready, u_hold); end
        reset = 1'b0;
        tick();
        checks++; if ({op_ready, u_clear} !== 2'b10) begin errors++;
            $display("FAIL reset_mid_release: got rdy%b clr%b", op_ready, u_clear); end
        model_hi = '0; model_lo = '0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; op_valid = 1'b0; op_code = '0; op_sign = 1'b0;
        op_a = '0; op_b = '0; rd_hi = 1'b0; rd_lo = 1'b0;
        u_write = 1'b0; u_hi_out = '0; u_lo_out = '0;
        test_reset();
        test_mthi_mtlo();
        test_mult();
        test_madd();
        test_flush();
        test_timeout();
        test_flush_write();
        test_back_to_back();
        test_reset_mid();
        checks++; if (exp_q.size() != 0) begin errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
